// File: rtl/mux_deser_pkg.sv
// rtl/mux_deser_pkg.sv - shared types and helpers for the serial-to-parallel collector
//
// Purpose : state encoding, counter-width helper and packing-direction constants
//           used by mux_deser and mux_deser_pack.
// Contents: state_e   - FSM states of the top level
//           CNT_W()   - width of a counter holding 0..WIDTH
//           PACK_*    - values of the MSB_FIRST parameter
package mux_deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam bit PACK_MSB_FIRST = 1'b1;
  localparam bit PACK_LSB_FIRST = 1'b0;

  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mux_deser_pack.sv
// rtl/mux_deser_pack.sv - assembly register, bit counter and word justification
//
// Purpose : accumulates serial bits into a word and presents the post-edge
//           (justified) word and count combinationally, so the top level can
//           move a word into its output register on the same edge the last
//           bit arrives.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           bit_i, shift_i  - serial bit and its accept strobe
//           clr_i           - word taken this edge; clear assembly and count
//           word_o          - justified word including this edge's bit
//           cnt_o           - bit count including this edge's bit
module mux_deser_pack
  import mux_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = CNT_W(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_i,
  input  logic             shift_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] word_o,
  output logic [CW-1:0]    cnt_o
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    just_sh;

  // Assembly/count as they stand after this edge's bit, before any clear.
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (shift_i) begin
      if (MSB_FIRST == PACK_MSB_FIRST) begin
        asm_d = {asm_q[WIDTH-2:0], bit_i};
      end else begin
        asm_d = asm_q | (WIDTH'(bit_i) << cnt_q);
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  // MSB-first partial words sit right-aligned in the shifter; move them up so
  // the first received bit is always the word's MSB.
  always_comb begin
    just_sh = FULL - cnt_d;
    if (MSB_FIRST == PACK_MSB_FIRST) begin
      word_o = asm_d << just_sh;
    end else begin
      word_o = asm_d;
    end
    cnt_o = cnt_d;
  end

  // Clear wins over shift: the bit arriving with a transfer belongs to the
  // word that just left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_deser.sv
// rtl/mux_deser.sv - serial-to-parallel collector with valid/ready word output
//
// Purpose : samples qualified serial bits, packs WIDTH of them (or fewer on
//           flush) into a word, and holds it in a one-word output register
//           with one pending assembly slot behind it.
// Ports   : clk, rst_n                  - clock, asynchronous active-low reset
//           in_bit, in_valid, in_ready  - serial input and its accept status
//           flush                       - emit a partial word
//           out_data, out_count         - word and its number of valid bits
//           out_valid, out_ready        - output handshake
//           overrun, clr_overrun        - sticky dropped-bit flag and its clear
module mux_deser
  import mux_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic [CNT_W(WIDTH)-1:0]  out_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             shift_en;
  logic             load;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_nxt;
  logic             slot_free;
  logic             word_done;

  mux_deser_pack #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_i   (in_bit),
    .shift_i (shift_en),
    .clr_i   (load),
    .word_o  (word),
    .cnt_o   (cnt_nxt)
  );

  assign slot_free = !out_valid_q || out_ready;
  // A flush only closes a word if there is at least one bit, counting a bit
  // that arrives on the same edge.
  assign word_done = (cnt_nxt == FULL) || (flush && (cnt_nxt != '0));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (word_done && !slot_free) state_d = PENDING;
      PENDING: if (slot_free)               state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs. In PENDING the shifter is frozen, so word/cnt_nxt are the
  // held word and the same path serves both transfer cases.
  always_comb begin
    in_ready = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        load     = word_done && slot_free;
      end
      PENDING: begin
        load     = slot_free;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = word;
      out_count_d = cnt_nxt;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set wins over clear.
    overrun_d = (overrun_q && !clr_overrun) || ((state_q == PENDING) && in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mux_deser.sv
// tb/tb_mux_deser.sv - directed self-checking bench for mux_deser
module tb_mux_deser;

  logic       clk;
  logic       rst_n;
  logic       in_bit;
  logic       in_valid;
  logic       flush;
  logic       out_ready;
  logic       clr_overrun;

  logic       m_in_ready, m_out_valid, m_overrun;
  logic [7:0] m_out_data;
  logic [3:0] m_out_count;
  logic       l_in_ready, l_out_valid, l_overrun;
  logic [7:0] l_out_data;
  logic [3:0] l_out_count;

  int errors = 0;
  int checks = 0;

  mux_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_ready    (m_in_ready),
    .flush       (flush),
    .out_data    (m_out_data),
    .out_count   (m_out_count),
    .out_valid   (m_out_valid),
    .out_ready   (out_ready),
    .overrun     (m_overrun),
    .clr_overrun (clr_overrun)
  );

  mux_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_ready    (l_in_ready),
    .flush       (flush),
    .out_data    (l_out_data),
    .out_count   (l_out_count),
    .out_valid   (l_out_valid),
    .out_ready   (out_ready),
    .overrun     (l_overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic b, input logic v, input logic f);
    in_bit   = b;
    in_valid = v;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Send a byte in time order w[7] first.
  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    rst_n       = 1'b0;
    in_bit      = 1'b0;
    in_valid    = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b1;
    clr_overrun = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_out_data",  m_out_data,  8'h00);
    chk("rst_out_count", m_out_count, 4'd0);
    chk("rst_overrun",   m_overrun,   1'b0);
    chk("rst_in_ready",  m_in_ready,  1'b1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word 1,0,1,1,0,0,1,0 on both packing directions
    w = 8'hB2;
    for (int i = 7; i >= 1; i--) step(w[i], 1'b1, 1'b0);
    chk("w1_valid_before_last", m_out_valid, 1'b0);
    step(w[0], 1'b1, 1'b0);
    chk("w1_valid",      m_out_valid, 1'b1);
    chk("w1_data_msb",   m_out_data,  8'hB2);
    chk("w1_count",      m_out_count, 4'd8);
    chk("w1_data_lsb",   l_out_data,  8'h4D);
    chk("w1_count_lsb",  l_out_count, 4'd8);
    step(1'b0, 1'b0, 1'b0);
    chk("w1_valid_one_cycle", m_out_valid, 1'b0);

    // Back-to-back words
    send_byte(8'hB2);
    chk("b2b_first_valid", m_out_valid, 1'b1);
    chk("b2b_first_data",  m_out_data,  8'hB2);
    w = 8'h5A;
    step(w[7], 1'b1, 1'b0);
    chk("b2b_gap_valid", m_out_valid, 1'b0);
    for (int i = 6; i >= 0; i--) step(w[i], 1'b1, 1'b0);
    chk("b2b_second_valid", m_out_valid, 1'b1);
    chk("b2b_second_data",  m_out_data,  8'h5A);
    chk("b2b_in_ready",     m_in_ready,  1'b1);
    chk("b2b_overrun",      m_overrun,   1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Backpressure: hold, pending, overrun, drain
    out_ready = 1'b0;
    send_byte(8'hFF);
    chk("bp_first_valid", m_out_valid, 1'b1);
    chk("bp_first_data",  m_out_data,  8'hFF);
    chk("bp_in_ready_after_8", m_in_ready, 1'b1);
    send_byte(8'h0F);
    chk("bp_hold_data",     m_out_data, 8'hFF);
    chk("bp_in_ready_low",  m_in_ready, 1'b0);
    chk("bp_no_overrun_yet", m_overrun, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("bp_overrun",       m_overrun,  1'b1);
    chk("bp_hold_data2",    m_out_data, 8'hFF);
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("bp_second_valid",  m_out_valid, 1'b1);
    chk("bp_second_data",   m_out_data,  8'h0F);
    chk("bp_in_ready_back", m_in_ready,  1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("bp_drained",       m_out_valid, 1'b0);
    clr_overrun = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_overrun = 1'b0;
    chk("bp_overrun_cleared", m_overrun, 1'b0);

    // Flush of a partial word, then an empty flush
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("fl_not_yet", m_out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("fl_valid", m_out_valid, 1'b1);
    chk("fl_data",  m_out_data,  8'hC0);
    chk("fl_count", m_out_count, 4'd3);
    chk("fl_data_lsb", l_out_data, 8'h03);
    step(1'b0, 1'b0, 1'b1);
    chk("fl_empty_no_valid", m_out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("fl_empty_still_idle", m_out_valid, 1'b0);

    // Asynchronous reset mid-word with overrun set
    out_ready = 1'b0;
    send_byte(8'hFF);
    send_byte(8'hFF);
    step(1'b1, 1'b1, 1'b0);
    chk("ar_overrun_set", m_overrun, 1'b1);
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("ar_overrun_before", m_overrun, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", m_out_valid, 1'b0);
    chk("ar_overrun",   m_overrun,   1'b0);
    chk("ar_out_data",  m_out_data,  8'h00);
    chk("ar_in_ready",  m_in_ready,  1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    w = 8'h3C;
    for (int i = 7; i >= 1; i--) step(w[i], 1'b1, 1'b0);
    chk("ar_no_residual", m_out_valid, 1'b0);
    step(w[0], 1'b1, 1'b0);
    chk("ar_valid",    m_out_valid, 1'b1);
    chk("ar_data",     m_out_data,  8'h3C);
    chk("ar_count",    m_out_count, 4'd8);
    chk("ar_data_lsb", l_out_data,  8'h3C);
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_deser.md
Name: mux_deser

Overview:
- Downstream stage for the 2:1 bit mux: samples the mux's 1-bit output on qualified cycles and packs WIDTH consecutive bits into a parallel word.
- Presents each word on a valid/ready output port backed by a one-word output register plus one pending assembly slot.
- Used in the layered benches as a scoreboard-friendly collector, and as the serial-to-parallel front end for the mux datapath.

Parameters:
- WIDTH, 8, number of bits per assembled word (>=2).
- MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bit  input  1  serial data, driven by the mux output.
- in_valid  input  1  in_bit is sampled on this edge.
- in_ready  output  1  high while a new bit can be accepted (state COLLECT).
- flush  input  1  sync request to emit a partially assembled word.
- out_data  output  WIDTH  assembled word.
- out_count  output  $clog2(WIDTH+1)  number of valid bits in out_data (WIDTH, or fewer after flush).
- out_valid  output  1  out_data/out_count valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- overrun  output  1  sticky: a bit was dropped.
- clr_overrun  input  1  sync clear of overrun; set wins if both occur on the same edge.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (immediate on rst_n low): state=COLLECT, bit count=0, assembly reg=0, out_valid=0, out_data=0, out_count=0, overrun=0, in_ready=1.
- Output slot is free on an edge when out_valid==0 or (out_valid && out_ready).
- Bit packing:
  - MSB_FIRST=1: assembly shifts left, new bit enters at LSB; a partial word is left-justified with zero fill below.
  - MSB_FIRST=0: the k-th bit goes to bit k; unused upper bits are 0.
- State COLLECT:
  - in_valid: bit stored, count+1.
  - Word complete (count reaches WIDTH on this edge) or flush with post-edge count>0 (bit arriving with flush is included):
    - slot free: word moves to the output register on the same edge; out_valid=1 next cycle (latency 1 from the last bit); count=0; stay in COLLECT.
    - slot not free: go to PENDING; assembly held.
  - flush with count==0 and no in_valid: no effect.
- State PENDING:
  - in_ready=0; any in_valid bit is dropped and sets overrun, including on the transfer edge.
  - flush is ignored.
  - When the slot becomes free, the word transfers, count=0, and the state returns to COLLECT.
- out_data/out_count remain stable while out_valid && !out_ready.
- out_valid drops the edge after a handshake unless a new word transfers on that same edge (back-to-back words, no bubble).
- No wrap: count never exceeds WIDTH; every word is emitted exactly once, in order.
- Reset mid-word discards all partial and pending data; no stale bits after reset release.

Decomposition:
- Package mux_deser_pkg:
  - state_e enum {COLLECT, PENDING}.
  - CNT_W function returning $clog2(WIDTH+1).
  - Packing-direction localparams.
- One sub-module: mux_deser_pack (assembly shift register + bit counter + justification).
- Top level holds the FSM, output register, and overrun.

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'hB2, out_count=8, out_valid high the cycle after the 8th bit, for 1 cycle.
- Two back-to-back words 0xB2 then 0x5A, out_ready=1 -> two single-cycle valids 8 cycles apart, in_ready stays 1, overrun=0.
- out_ready=0, send 0xFF then 0x0F, then one more in_valid bit:
  - out_data held at 0xFF; in_ready=0 after the 16th bit; overrun=1.
  - Raise out_ready -> 0xFF then 0x0F emitted; in_ready=1 again.
- Bits 1,1,0 then flush -> out_data=8'hC0, out_count=3; a second flush with count 0 -> no out_valid.
- MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 -> out_data=8'h4D, out_count=8.
- Assert rst_n low asynchronously after 5 bits with overrun=1:
  - out_valid=0 and overrun=0 without a clock edge.
  - After release, bits 0,0,1,1,1,1,0,0 -> 8'h3C with no residual bits.
